// File: rtl/bypass_history_network.sv
// Operand bypass network: forwards from preg 0, ALU results, the live CDB and a short history
// of past CDB broadcasts (covering PRF write latency) before falling back to the PRF read.
module bypass_history_network #(
    parameter int unsigned NUM_PHYS_REGS = 64,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned CDB_WIDTH     = 4,
    parameter int unsigned NUM_ALU       = 2,
    parameter int unsigned FORWARD_PORTS = 8,
    parameter int unsigned HIST_DEPTH    = 2,
    parameter int unsigned REG_OUT       = 0,
    localparam int unsigned PB    = $clog2(NUM_PHYS_REGS),
    localparam int unsigned OCC_W = (HIST_DEPTH * CDB_WIDTH > 0) ?
                                    $clog2(HIST_DEPTH * CDB_WIDTH + 1) : 1
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     flush,
    input  logic [FORWARD_PORTS-1:0]                 req_valid,
    input  logic [FORWARD_PORTS-1:0][PB-1:0]         req_tag,
    input  logic [CDB_WIDTH-1:0]                     cdb_valid,
    input  logic [CDB_WIDTH-1:0][PB-1:0]             cdb_tag,
    input  logic [CDB_WIDTH-1:0][DATA_WIDTH-1:0]     cdb_data,
    input  logic [NUM_ALU-1:0]                       alu_valid,
    input  logic [NUM_ALU-1:0][PB-1:0]               alu_prd,
    input  logic [NUM_ALU-1:0][DATA_WIDTH-1:0]       alu_data,
    input  logic [FORWARD_PORTS-1:0][DATA_WIDTH-1:0] prf_read_data,
    input  logic [FORWARD_PORTS-1:0]                 prf_read_ready,
    output logic [FORWARD_PORTS-1:0][DATA_WIDTH-1:0] fwd_data,
    output logic [FORWARD_PORTS-1:0]                 fwd_valid,
    output logic [FORWARD_PORTS-1:0][2:0]            fwd_src,
    output logic [31:0]                              hit_cnt,
    output logic [OCC_W-1:0]                         hist_occ
);

    // Storage is sized to at least one row; with HIST_DEPTH=0 the valids are held at zero.
    localparam int unsigned HD = (HIST_DEPTH > 0) ? HIST_DEPTH : 1;
    localparam int unsigned HW = $clog2(FORWARD_PORTS + 1);

    typedef enum logic [2:0] {
        SrcPrf  = 3'd0,
        SrcZero = 3'd1,
        SrcAlu  = 3'd2,
        SrcCdb  = 3'd3,
        SrcHist = 3'd4
    } src_e;

    logic [HD-1:0][CDB_WIDTH-1:0]                 hv_q, hv_d;
    logic [HD-1:0][CDB_WIDTH-1:0][PB-1:0]         ht_q, ht_d;
    logic [HD-1:0][CDB_WIDTH-1:0][DATA_WIDTH-1:0] hd_q, hd_d;
    logic [OCC_W-1:0]                             occ_q, occ_d;
    logic [31:0]                                  hit_cnt_q, hit_cnt_d;

    logic [FORWARD_PORTS-1:0][DATA_WIDTH-1:0] lk_data;
    logic [FORWARD_PORTS-1:0]                 lk_valid;
    src_e [FORWARD_PORTS-1:0]                 lk_src;
    logic [HW-1:0]                            hit_sum;
    logic [32:0]                              cnt_sum;
    logic                                     found;

    // History shift: row 0 captures the live CDB, the oldest row falls off the end.
    always_comb begin
        hv_d = hv_q;
        ht_d = ht_q;
        hd_d = hd_q;
        if (HIST_DEPTH > 0) begin
            for (int r = int'(HD) - 1; r > 0; r--) begin
                hv_d[r] = hv_q[r-1];
                ht_d[r] = ht_q[r-1];
                hd_d[r] = hd_q[r-1];
            end
            hv_d[0] = cdb_valid;
            ht_d[0] = cdb_tag;
            hd_d[0] = cdb_data;
            if (flush) begin
                hv_d = '0;
            end
        end else begin
            hv_d = '0;
        end
    end

    always_comb begin
        occ_d = '0;
        for (int r = 0; r < int'(HD); r++) begin
            for (int l = 0; l < int'(CDB_WIDTH); l++) begin
                occ_d = occ_d + OCC_W'(hv_d[r][l]);
            end
        end
    end

    // Per-port priority lookup: zero reg, ALU, live CDB, history (youngest row first), PRF.
    always_comb begin
        hit_sum = '0;
        found   = 1'b0;
        for (int p = 0; p < int'(FORWARD_PORTS); p++) begin
            lk_data[p]  = prf_read_data[p];
            lk_valid[p] = prf_read_ready[p];
            lk_src[p]   = SrcPrf;
            found       = 1'b0;
            if (req_valid[p]) begin
                if (req_tag[p] == '0) begin
                    lk_data[p]  = '0;
                    lk_valid[p] = 1'b1;
                    lk_src[p]   = SrcZero;
                    found       = 1'b1;
                end
                for (int a = int'(NUM_ALU) - 1; a >= 0; a--) begin
                    if (!found && alu_valid[a] && (alu_prd[a] == req_tag[p])) begin
                        lk_data[p]  = alu_data[a];
                        lk_valid[p] = 1'b1;
                        lk_src[p]   = SrcAlu;
                        found       = 1'b1;
                    end
                end
                for (int l = int'(CDB_WIDTH) - 1; l >= 0; l--) begin
                    if (!found && cdb_valid[l] && (cdb_tag[l] == req_tag[p])) begin
                        lk_data[p]  = cdb_data[l];
                        lk_valid[p] = 1'b1;
                        lk_src[p]   = SrcCdb;
                        found       = 1'b1;
                    end
                end
                for (int r = 0; r < int'(HD); r++) begin
                    for (int l = int'(CDB_WIDTH) - 1; l >= 0; l--) begin
                        if (!found && (HIST_DEPTH > 0) && hv_q[r][l] &&
                            (ht_q[r][l] == req_tag[p])) begin
                            lk_data[p]  = hd_q[r][l];
                            lk_valid[p] = 1'b1;
                            lk_src[p]   = SrcHist;
                            found       = 1'b1;
                        end
                    end
                end
                if (found) begin
                    hit_sum = hit_sum + HW'(1);
                end
            end
        end
    end

    always_comb begin
        cnt_sum   = {1'b0, hit_cnt_q} + 33'(hit_sum);
        hit_cnt_d = cnt_sum[32] ? '1 : cnt_sum[31:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hv_q      <= '0;
            ht_q      <= '0;
            hd_q      <= '0;
            occ_q     <= '0;
            hit_cnt_q <= '0;
        end else begin
            hv_q      <= hv_d;
            ht_q      <= ht_d;
            hd_q      <= hd_d;
            occ_q     <= occ_d;
            hit_cnt_q <= hit_cnt_d;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign hist_occ = occ_q;

    if (REG_OUT != 0) begin : g_reg_out
        logic [FORWARD_PORTS-1:0][DATA_WIDTH-1:0] out_data_q;
        logic [FORWARD_PORTS-1:0]                 out_valid_q;
        logic [FORWARD_PORTS-1:0][2:0]            out_src_q;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                out_data_q  <= '0;
                out_valid_q <= '0;
                out_src_q   <= '0;
            end else begin
                out_data_q  <= lk_data;
                out_valid_q <= lk_valid;
                out_src_q   <= lk_src;
            end
        end

        assign fwd_data  = out_data_q;
        assign fwd_valid = out_valid_q;
        assign fwd_src   = out_src_q;
    end else begin : g_comb_out
        assign fwd_data  = lk_data;
        assign fwd_valid = lk_valid;
        assign fwd_src   = lk_src;
    end

endmodule

// File: tb/tb_bypass_history_network.sv
// Bench for bypass_history_network: directed vector table, hand sequences for history/flush/
// reset/saturation, and random traffic checked against a queue-based reference model.
module tb_bypass_history_network;

    localparam int FP = 8, CW = 4, NA = 2, DW = 32, PB = 6, HD = 2, OW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush;
    logic [FP-1:0]          req_valid;
    logic [FP-1:0][PB-1:0]  req_tag;
    logic [CW-1:0]          cdb_valid;
    logic [CW-1:0][PB-1:0]  cdb_tag;
    logic [CW-1:0][DW-1:0]  cdb_data;
    logic [NA-1:0]          alu_valid;
    logic [NA-1:0][PB-1:0]  alu_prd;
    logic [NA-1:0][DW-1:0]  alu_data;
    logic [FP-1:0][DW-1:0]  prf_read_data;
    logic [FP-1:0]          prf_read_ready;

    logic [FP-1:0][DW-1:0]  fwd_data0, fwd_data1;
    logic [FP-1:0]          fwd_valid0, fwd_valid1;
    logic [FP-1:0][2:0]     fwd_src0, fwd_src1;
    logic [31:0]            hit_cnt0, hit_cnt1;
    logic [OW-1:0]          hist_occ0, hist_occ1;

    always #5 clk = ~clk;

    bypass_history_network #(.REG_OUT(0)) dut0 (
        .clk(clk), .rst(rst), .flush(flush), .req_valid(req_valid), .req_tag(req_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .alu_valid(alu_valid), .alu_prd(alu_prd), .alu_data(alu_data),
        .prf_read_data(prf_read_data), .prf_read_ready(prf_read_ready),
        .fwd_data(fwd_data0), .fwd_valid(fwd_valid0), .fwd_src(fwd_src0),
        .hit_cnt(hit_cnt0), .hist_occ(hist_occ0)
    );

    bypass_history_network #(.REG_OUT(1)) dut1 (
        .clk(clk), .rst(rst), .flush(flush), .req_valid(req_valid), .req_tag(req_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .alu_valid(alu_valid), .alu_prd(alu_prd), .alu_data(alu_data),
        .prf_read_data(prf_read_data), .prf_read_ready(prf_read_ready),
        .fwd_data(fwd_data1), .fwd_valid(fwd_valid1), .fwd_src(fwd_src1),
        .hit_cnt(hit_cnt1), .hist_occ(hist_occ1)
    );

    int errors = 0;
    int checks = 0;

    // Reference history: one entry per past broadcast cycle, youngest at index 0.
    typedef struct {
        logic [CW-1:0]         v;
        logic [CW-1:0][PB-1:0] t;
        logic [CW-1:0][DW-1:0] d;
    } row_t;
    row_t hq[$];
    logic [31:0] m_hit;

    logic [FP-1:0][DW-1:0] e_data, p_data;
    logic [FP-1:0]         e_valid, p_valid;
    logic [FP-1:0][2:0]    e_src, p_src;

    typedef struct {
        logic rv; logic [PB-1:0] tag;
        logic [1:0] av; logic [PB-1:0] at0; logic [DW-1:0] ad0;
        logic [PB-1:0] at1; logic [DW-1:0] ad1;
        logic [3:0] cv; logic [PB-1:0] ct0; logic [DW-1:0] cd0;
        logic [PB-1:0] ct3; logic [DW-1:0] cd3;
        logic [DW-1:0] pd; logic pr;
        logic [DW-1:0] ed; logic ev; logic [2:0] es;
    } vec_t;
    vec_t tbl[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int m_occ();
        int n = 0;
        foreach (hq[r]) n += $countones(hq[r].v);
        return n;
    endfunction

    task automatic ref_lookup(input int p, output logic [DW-1:0] d, output logic v,
                              output logic [2:0] s);
        d = prf_read_data[p];
        v = prf_read_ready[p];
        s = 3'd0;
        if (!req_valid[p]) return;
        if (req_tag[p] == 0) begin
            d = '0; v = 1'b1; s = 3'd1; return;
        end
        for (int a = NA - 1; a >= 0; a--)
            if (alu_valid[a] && alu_prd[a] == req_tag[p]) begin
                d = alu_data[a]; v = 1'b1; s = 3'd2; return;
            end
        for (int l = CW - 1; l >= 0; l--)
            if (cdb_valid[l] && cdb_tag[l] == req_tag[p]) begin
                d = cdb_data[l]; v = 1'b1; s = 3'd3; return;
            end
        foreach (hq[r])
            for (int l = CW - 1; l >= 0; l--)
                if (hq[r].v[l] && hq[r].t[l] == req_tag[p]) begin
                    d = hq[r].d[l]; v = 1'b1; s = 3'd4; return;
                end
    endtask

    // Compare both DUTs against the model, away from the active edge.
    task automatic sample();
        logic [DW-1:0] d;
        logic v;
        logic [2:0] s;
        @(negedge clk);
        for (int p = 0; p < FP; p++) begin
            ref_lookup(p, d, v, s);
            e_data[p] = d; e_valid[p] = v; e_src[p] = s;
            chk($sformatf("comb_data[%0d]", p), 64'(fwd_data0[p]), 64'(d));
            chk($sformatf("comb_valid[%0d]", p), 64'(fwd_valid0[p]), 64'(v));
            chk($sformatf("comb_src[%0d]", p), 64'(fwd_src0[p]), 64'(s));
            chk($sformatf("reg_data[%0d]", p), 64'(fwd_data1[p]), 64'(p_data[p]));
            chk($sformatf("reg_valid[%0d]", p), 64'(fwd_valid1[p]), 64'(p_valid[p]));
            chk($sformatf("reg_src[%0d]", p), 64'(fwd_src1[p]), 64'(p_src[p]));
        end
        chk("hit_cnt0", 64'(hit_cnt0), 64'(m_hit));
        chk("hit_cnt1", 64'(hit_cnt1), 64'(m_hit));
        chk("hist_occ0", 64'(hist_occ0), 64'(m_occ()));
        chk("hist_occ1", 64'(hist_occ1), 64'(m_occ()));
    endtask

    task automatic model_reset();
        hq.delete();
        m_hit = '0;
        p_data = '0; p_valid = '0; p_src = '0;
    endtask

    task automatic advance();
        longint hits;
        row_t nr;
        @(posedge clk);
        if (!rst) begin
            model_reset();
        end else begin
            hits = 0;
            for (int p = 0; p < FP; p++) if (req_valid[p] && e_src[p] != 3'd0) hits++;
            m_hit = (longint'(m_hit) + hits > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF :
                    32'(longint'(m_hit) + hits);
            p_data = e_data; p_valid = e_valid; p_src = e_src;
            if (flush) begin
                hq.delete();
            end else begin
                nr.v = cdb_valid; nr.t = cdb_tag; nr.d = cdb_data;
                hq.push_front(nr);
                if (hq.size() > HD) void'(hq.pop_back());
            end
        end
        #1;
    endtask

    task automatic idle();
        flush = 1'b0;
        req_valid = '0; req_tag = '0;
        cdb_valid = '0; cdb_tag = '0; cdb_data = '0;
        alu_valid = '0; alu_prd = '0; alu_data = '0;
        prf_read_data = '0; prf_read_ready = '0;
    endtask

    task automatic clear_hist();
        idle(); flush = 1'b1; sample(); advance(); idle();
    endtask

    task automatic req0(input logic [PB-1:0] t);
        req_valid[0] = 1'b1; req_tag[0] = t; prf_read_ready[0] = 1'b0;
        prf_read_data[0] = 32'hDEAD;
    endtask

    task automatic fill_hist(input logic [PB-1:0] base);
        for (int c = 0; c < 2; c++) begin
            cdb_valid = '1;
            for (int l = 0; l < CW; l++) begin
                cdb_tag[l]  = base + PB'(c * CW + l);
                cdb_data[l] = 32'h300 + 32'(c * CW + l);
            end
            sample(); advance();
        end
    endtask

    initial begin
        //        rv    tag    av     at0    ad0       at1    ad1      cv       ct0    cd0
        //        ct3   cd3        pd          pr    ed          ev    es
        tbl[0] = '{1'b1, 6'd9,  2'b10, 6'd0,  32'h0,    6'd9,  32'h11,  4'b0001, 6'd9,  32'h22,
                   6'd0, 32'h0,    32'h99,     1'b1, 32'h11,     1'b1, 3'd2};
        tbl[1] = '{1'b1, 6'd9,  2'b00, 6'd0,  32'h0,    6'd0,  32'h0,   4'b0001, 6'd9,  32'h22,
                   6'd0, 32'h0,    32'h99,     1'b1, 32'h22,     1'b1, 3'd3};
        tbl[2] = '{1'b1, 6'd0,  2'b00, 6'd0,  32'h0,    6'd0,  32'h0,   4'b0001, 6'd0,  32'hFFFF,
                   6'd0, 32'h0,    32'h77,     1'b0, 32'h0,      1'b1, 3'd1};
        tbl[3] = '{1'b1, 6'd7,  2'b00, 6'd0,  32'h0,    6'd0,  32'h0,   4'b1001, 6'd7,  32'hC0,
                   6'd7, 32'hC3,   32'h0,      1'b0, 32'hC3,     1'b1, 3'd3};
        tbl[4] = '{1'b1, 6'd12, 2'b00, 6'd0,  32'h0,    6'd0,  32'h0,   4'b0000, 6'd0,  32'h0,
                   6'd0, 32'h0,    32'h1234,   1'b1, 32'h1234,   1'b1, 3'd0};
        tbl[5] = '{1'b1, 6'd12, 2'b00, 6'd0,  32'h0,    6'd0,  32'h0,   4'b0000, 6'd0,  32'h0,
                   6'd0, 32'h0,    32'h55,     1'b0, 32'h55,     1'b0, 3'd0};
        tbl[6] = '{1'b1, 6'd20, 2'b11, 6'd20, 32'hA0,   6'd20, 32'hA1,  4'b0001, 6'd20, 32'hC0,
                   6'd0, 32'h0,    32'h0,      1'b0, 32'hA1,     1'b1, 3'd2};
        tbl[7] = '{1'b1, 6'd21, 2'b00, 6'd21, 32'hBB,   6'd0,  32'h0,   4'b0000, 6'd21, 32'hCC,
                   6'd0, 32'h0,    32'h66,     1'b1, 32'h66,     1'b1, 3'd0};
        tbl[8] = '{1'b0, 6'd9,  2'b10, 6'd0,  32'h0,    6'd9,  32'h11,  4'b0000, 6'd0,  32'h0,
                   6'd0, 32'h0,    32'h88,     1'b0, 32'h88,     1'b0, 3'd0};
        tbl[9] = '{1'b1, 6'd13, 2'b11, 6'd13, 32'h5A,   6'd14, 32'h5B,  4'b0000, 6'd0,  32'h0,
                   6'd0, 32'h0,    32'h0,      1'b0, 32'h5A,     1'b1, 3'd2};

        idle();
        model_reset();
        #1 rst = 1'b0;
        #2;
        chk("reset_hit_cnt", 64'(hit_cnt0), 64'h0);
        chk("reset_hist_occ", 64'(hist_occ0), 64'h0);
        chk("reset_reg_valid", 64'(fwd_valid1), 64'h0);
        chk("reset_reg_src", 64'(fwd_src1), 64'h0);
        @(posedge clk);
        #1 rst = 1'b1;

        // Single-cycle priority vectors; flush keeps each vector out of the next one's history.
        foreach (tbl[i]) begin
            idle();
            flush = 1'b1;
            req_valid[0] = tbl[i].rv; req_tag[0] = tbl[i].tag;
            alu_valid = tbl[i].av;
            alu_prd[0] = tbl[i].at0; alu_data[0] = tbl[i].ad0;
            alu_prd[1] = tbl[i].at1; alu_data[1] = tbl[i].ad1;
            cdb_valid = tbl[i].cv;
            cdb_tag[0] = tbl[i].ct0; cdb_data[0] = tbl[i].cd0;
            cdb_tag[3] = tbl[i].ct3; cdb_data[3] = tbl[i].cd3;
            prf_read_data[0] = tbl[i].pd; prf_read_ready[0] = tbl[i].pr;
            sample();
            chk($sformatf("vec%0d_data", i), 64'(fwd_data0[0]), 64'(tbl[i].ed));
            chk($sformatf("vec%0d_valid", i), 64'(fwd_valid0[0]), 64'(tbl[i].ev));
            chk($sformatf("vec%0d_src", i), 64'(fwd_src0[0]), 64'(tbl[i].es));
            advance();
        end

        // History lifetime: visible for HD cycles after the broadcast, then PRF.
        clear_hist();
        cdb_valid[1] = 1'b1; cdb_tag[1] = 6'd5; cdb_data[1] = 32'hAAAA;
        sample(); advance(); idle();
        req0(6'd5); sample();
        chk("hist_t1_data", 64'(fwd_data0[0]), 64'hAAAA);
        chk("hist_t1_valid", 64'(fwd_valid0[0]), 64'h1);
        chk("hist_t1_src", 64'(fwd_src0[0]), 64'h4);
        advance();
        sample();
        chk("hist_t2_src", 64'(fwd_src0[0]), 64'h4);
        advance();
        sample();
        chk("hist_t3_src", 64'(fwd_src0[0]), 64'h0);
        chk("hist_t3_valid", 64'(fwd_valid0[0]), 64'h0);
        advance();

        // HIST < CDB < ALU across consecutive cycles.
        clear_hist();
        cdb_valid[0] = 1'b1; cdb_tag[0] = 6'd9; cdb_data[0] = 32'h33;
        sample(); advance(); idle();
        req0(6'd9); sample();
        chk("prio_hist", 64'(fwd_data0[0]), 64'h33);
        advance();
        cdb_valid[0] = 1'b1; cdb_tag[0] = 6'd9; cdb_data[0] = 32'h22;
        sample();
        chk("prio_cdb", 64'(fwd_data0[0]), 64'h22);
        chk("prio_cdb_src", 64'(fwd_src0[0]), 64'h3);
        advance();
        alu_valid[1] = 1'b1; alu_prd[1] = 6'd9; alu_data[1] = 32'h11;
        sample();
        chk("prio_alu", 64'(fwd_data0[0]), 64'h11);
        advance();

        // Youngest row wins; highest lane wins within a row.
        clear_hist();
        cdb_valid[2] = 1'b1; cdb_tag[2] = 6'd7; cdb_data[2] = 32'hB1;
        sample(); advance(); idle();
        cdb_valid[0] = 1'b1; cdb_tag[0] = 6'd7; cdb_data[0] = 32'hB0;
        sample(); advance(); idle();
        req0(6'd7); sample();
        chk("young_row", 64'(fwd_data0[0]), 64'hB0);
        advance();
        clear_hist();
        cdb_valid = 4'b1001; cdb_tag[0] = 6'd7; cdb_tag[3] = 6'd7;
        cdb_data[0] = 32'hD0; cdb_data[3] = 32'hD3;
        sample(); advance(); idle();
        req0(6'd7); sample();
        chk("high_lane_hist", 64'(fwd_data0[0]), 64'hD3);
        chk("high_lane_src", 64'(fwd_src0[0]), 64'h4);
        advance();

        // Full history, then flush: old history still visible in the flush cycle only.
        clear_hist();
        fill_hist(6'd30);
        idle();
        req0(6'd30); flush = 1'b1;
        sample();
        chk("full_occ", 64'(hist_occ0), 64'd8);
        chk("flush_cycle_hit", 64'(fwd_data0[0]), 64'h300);
        advance();
        idle(); req0(6'd30);
        sample();
        chk("flush_occ", 64'(hist_occ0), 64'd0);
        chk("flush_src", 64'(fwd_src0[0]), 64'h0);
        advance();

        // Asynchronous reset mid-stream.
        idle();
        req_valid = '1;
        fill_hist(6'd40);
        rst = 1'b0;
        model_reset();
        #1;
        chk("areset_occ", 64'(hist_occ0), 64'h0);
        chk("areset_hit0", 64'(hit_cnt0), 64'h0);
        chk("areset_hit1", 64'(hit_cnt1), 64'h0);
        chk("areset_reg_valid", 64'(fwd_valid1), 64'h0);
        chk("areset_reg_data", 64'(fwd_data1[0]), 64'h0);
        idle(); req0(6'd40);
        sample();
        chk("areset_src", 64'(fwd_src0[0]), 64'h0);
        advance();
        rst = 1'b1;

        // Registered output lags the request by one cycle.
        idle(); sample(); advance();
        req0(6'd0); sample();
        chk("regout_t0_src", 64'(fwd_src1[0]), 64'h0);
        advance(); idle(); sample();
        chk("regout_t1_src", 64'(fwd_src1[0]), 64'h1);
        chk("regout_t1_valid", 64'(fwd_valid1[0]), 64'h1);
        advance();

        // Hit counter saturation.
        idle();
        force dut0.hit_cnt_q = 32'hFFFF_FFFE;
        force dut1.hit_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut0.hit_cnt_q;
        release dut1.hit_cnt_q;
        m_hit = 32'hFFFF_FFFE;
        req_valid = '1;
        sample();
        chk("sat_start", 64'(hit_cnt0), 64'hFFFF_FFFE);
        advance(); sample();
        chk("sat_hold1", 64'(hit_cnt0), 64'hFFFF_FFFF);
        advance(); sample();
        chk("sat_hold2", 64'(hit_cnt1), 64'hFFFF_FFFF);
        advance();

        // Random traffic over a small tag space so every source collides often.
        for (int c = 0; c < 400; c++) begin
            flush = ($urandom_range(0, 19) == 0);
            req_valid = FP'($urandom);
            prf_read_ready = FP'($urandom);
            for (int p = 0; p < FP; p++) begin
                req_tag[p] = PB'($urandom_range(0, 15));
                prf_read_data[p] = $urandom;
            end
            cdb_valid = CW'($urandom);
            for (int l = 0; l < CW; l++) begin
                cdb_tag[l] = PB'($urandom_range(0, 15));
                cdb_data[l] = $urandom;
            end
            alu_valid = NA'($urandom);
            for (int a = 0; a < NA; a++) begin
                alu_prd[a] = PB'($urandom_range(0, 15));
                alu_data[a] = $urandom;
            end
            sample();
            advance();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
